// File: rtl/ram_readback_tx_if.sv
// Bundles the start/status, RAM read port and UART line of the frame readback transmitter.
// The master side is the transmitter; the slave side is the host logic and RAM around it.
interface ram_readback_tx_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] length;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_read_enable;
    logic [7:0]            ram_data_in;
    logic                  tx_out;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] bytes_sent;

    modport master (
        input  start, start_addr, length, ram_data_in,
        output ram_address, ram_read_enable, tx_out, busy, done, bytes_sent
    );

    modport slave (
        output start, start_addr, length, ram_data_in,
        input  ram_address, ram_read_enable, tx_out, busy, done, bytes_sent
    );
endinterface

// File: rtl/ram_readback_tx.sv
// Reads a span of frame RAM and sends it as one 8N1 UART packet: header, data bytes, XOR checksum.
// The next data byte is prefetched during the stop bit of the byte currently on the line.
module ram_readback_tx #(
    parameter int                          UART_TICKS_WIDTH   = 7,
    parameter logic [UART_TICKS_WIDTH-1:0] UART_TICKS_PER_BIT = 7'd65,
    parameter int                          ADDR_WIDTH         = 12,
    parameter logic [7:0]                  HEADER_BYTE        = 8'h44
) (
    input  logic               clk_in,
    input  logic               reset,
    ram_readback_tx_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE} state_t;

    localparam logic [UART_TICKS_WIDTH-1:0] TICK_LAST = UART_TICKS_PER_BIT - 1'b1;
    localparam logic [UART_TICKS_WIDTH-1:0] TICK_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0]       ADDR_ONE  = 1;

    state_t                      state_reg, state_next;
    logic [UART_TICKS_WIDTH-1:0] tick_reg;
    logic [3:0]                  bit_reg;
    logic [7:0]                  shift_reg;
    logic [7:0]                  next_byte_reg;
    logic [7:0]                  csum_reg;
    logic [ADDR_WIDTH-1:0]       len_reg;
    logic [ADDR_WIDTH-1:0]       fetch_addr_reg;
    logic [ADDR_WIDTH-1:0]       fetch_cnt_reg;
    logic [ADDR_WIDTH-1:0]       bytes_sent_reg;
    logic [ADDR_WIDTH-1:0]       ram_address_reg;
    logic                        rre_reg;
    logic                        capture_reg;

    logic       sending, bit_end, byte_end, accept, prefetch, last_data;
    logic [2:0] data_idx;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        sending    = (state_reg == S_HDR) || (state_reg == S_DATA) || (state_reg == S_CSUM);
        bit_end    = sending && (tick_reg == TICK_LAST);
        byte_end   = bit_end && (bit_reg == 4'd9);
        accept     = (state_reg == S_IDLE) && bus.start;
        last_data  = (bytes_sent_reg + ADDR_ONE) == len_reg;
        // Fetch early in the stop bit so the byte is captured well before the next start bit.
        prefetch   = ((state_reg == S_HDR) || (state_reg == S_DATA)) && (bit_reg == 4'd9)
                     && (tick_reg == '0) && (fetch_cnt_reg != len_reg);
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_HDR;
            S_HDR:   if (byte_end) state_next = (len_reg == '0) ? S_CSUM : S_DATA;
            S_DATA:  if (byte_end && last_data) state_next = S_CSUM;
            S_CSUM:  if (byte_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick_reg        <= '0;
            bit_reg         <= '0;
            shift_reg       <= '0;
            next_byte_reg   <= '0;
            csum_reg        <= '0;
            len_reg         <= '0;
            fetch_addr_reg  <= '0;
            fetch_cnt_reg   <= '0;
            bytes_sent_reg  <= '0;
            ram_address_reg <= '0;
            rre_reg         <= 1'b0;
            capture_reg     <= 1'b0;
        end else begin
            rre_reg     <= prefetch;
            capture_reg <= rre_reg;
            if (accept) begin
                len_reg        <= bus.length;
                fetch_addr_reg <= bus.start_addr;
                fetch_cnt_reg  <= '0;
                bytes_sent_reg <= '0;
                csum_reg       <= '0;
                shift_reg      <= HEADER_BYTE;
                tick_reg       <= '0;
                bit_reg        <= '0;
            end else if (sending) begin
                if (bit_end) begin
                    tick_reg <= '0;
                    if (bit_reg == 4'd9) begin
                        bit_reg   <= '0;
                        shift_reg <= (state_next == S_CSUM) ? csum_reg : next_byte_reg;
                        if (state_reg == S_DATA) bytes_sent_reg <= bytes_sent_reg + ADDR_ONE;
                    end else begin
                        bit_reg <= bit_reg + 4'd1;
                    end
                end else begin
                    tick_reg <= tick_reg + TICK_ONE;
                end
            end
            if (prefetch) begin
                ram_address_reg <= fetch_addr_reg;
                fetch_addr_reg  <= fetch_addr_reg + ADDR_ONE;
                fetch_cnt_reg   <= fetch_cnt_reg + ADDR_ONE;
            end
            // Every fetched byte is a data byte, so fold it into the checksum on capture.
            if (capture_reg) begin
                next_byte_reg <= bus.ram_data_in;
                csum_reg      <= csum_reg ^ bus.ram_data_in;
            end
        end
    end

    assign data_idx            = bit_reg[2:0] - 3'd1;
    assign bus.tx_out          = !sending ? 1'b1 :
                                 (bit_reg == 4'd0) ? 1'b0 :
                                 (bit_reg == 4'd9) ? 1'b1 : shift_reg[data_idx];
    assign bus.busy            = sending;
    assign bus.done            = (state_reg == S_DONE);
    assign bus.ram_address     = ram_address_reg;
    assign bus.ram_read_enable = rre_reg;
    assign bus.bytes_sent      = bytes_sent_reg;
endmodule

// File: tb/tb_ram_readback_tx.sv
// Directed and randomized packets against a byte-list model of the readback packet.
module tb_ram_readback_tx;
    localparam int T        = 65;
    localparam int BYTE_CYC = 10 * T;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0]  mem [4096];
    logic [11:0] rd_q [$];

    ram_readback_tx_if #(.ADDR_WIDTH(12)) bus ();

    ram_readback_tx #(
        .UART_TICKS_WIDTH(7), .UART_TICKS_PER_BIT(7'd65),
        .ADDR_WIDTH(12), .HEADER_BYTE(8'h44)
    ) dut (
        .clk_in(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM: data valid the cycle after a strobe, noise on the bus at all other times.
    always @(posedge clk) begin
        if (bus.ram_read_enable === 1'b1) begin
            rd_q.push_back(bus.ram_address);
            bus.ram_data_in <= mem[bus.ram_address];
        end else begin
            bus.ram_data_in <= 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.ram_read_enable !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check(tag, bad, 0);
    endtask

    // Runs one packet from the accepting edge; abort_at >= 0 asserts reset at that packet cycle.
    task automatic run_pkt(input logic [11:0] a, input logic [11:0] n,
                           input int abort_at, input bit interfere);
        logic [7:0] exp_q [$];
        logic [7:0] dec [$];
        logic [7:0] cs = 8'h00;
        logic [7:0] cur;
        logic       exp_bit;
        int pkt_cyc, k, j;
        int line_err = 0;
        int ctl_err  = 0;
        int rd_err   = 0;

        exp_q.push_back(8'h44);
        for (int i = 0; i < int'(n); i++) begin
            cur = mem[12'(a + i)];
            cs  = cs ^ cur;
            exp_q.push_back(cur);
        end
        exp_q.push_back(cs);
        for (int i = 0; i < int'(n) + 2; i++) dec.push_back(8'h00);
        pkt_cyc = (int'(n) + 2) * BYTE_CYC;

        rd_q.delete();
        bus.start_addr = a;
        bus.length     = n;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);

        for (int c = 0; c < pkt_cyc; c++) begin
            k = c / BYTE_CYC;
            j = (c % BYTE_CYC) / T;
            if (c == abort_at) begin
                #3 reset = 1'b0;
                #1;
                check("async_tx_high", bus.tx_out, 1);
                check("async_busy_low", bus.busy, 0);
                check("async_done_low", bus.done, 0);
                check("async_rre_low", bus.ram_read_enable, 0);
                check("async_addr_zero", bus.ram_address, 0);
                repeat (3) @(posedge clk);
                check("held_tx_high", bus.tx_out, 1);
                #3 reset = 1'b1;
                @(posedge clk); #1;
                check("line_before_abort", line_err, 0);
                check_idle("idle_after_reset", 40);
                check("addr_after_reset", bus.ram_address, 0);
                check("bytes_sent_after_reset", bus.bytes_sent, 0);
                $display("abort addr=%03h n=%0d at cycle %0d", a, n, abort_at);
                return;
            end
            cur     = exp_q[k];
            exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : cur[j - 1];
            if (bus.tx_out !== exp_bit) line_err++;
            if (c % T == T / 2 && j >= 1 && j <= 8) begin
                cur        = dec[k];
                cur[j - 1] = bus.tx_out;
                dec[k]     = cur;
            end
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) ctl_err++;
            if (interfere && c == 500) begin
                bus.start      = 1'b1;
                bus.start_addr = 12'($urandom);
                bus.length     = 12'($urandom_range(1, 9));
            end
            if (interfere && c == 501) bus.start = 1'b0;
            @(posedge clk); #1;
        end

        check("done_cycle", {30'd0, bus.done, bus.busy}, 32'b10);
        check("tx_timing", line_err, 0);
        check("busy_during_pkt", ctl_err, 0);
        for (int i = 0; i < int'(n) + 2; i++) check("byte", dec[i], exp_q[i]);
        check("strobe_count", rd_q.size(), n);
        for (int i = 0; i < rd_q.size() && i < int'(n); i++)
            if (rd_q[i] !== 12'(a + i)) rd_err++;
        check("read_addr", rd_err, 0);
        check("bytes_sent", bus.bytes_sent, n);

        // start during the done cycle must be ignored
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_one_cycle", bus.done, 0);
        check_idle("idle_after_done", interfere ? 800 : 20);
        check("bytes_sent_hold", bus.bytes_sent, n);
        check("no_extra_strobes", rd_q.size(), n);
        $display("packet addr=%03h n=%0d csum=%02h cycles=%0d", a, n, cs, pkt_cyc);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk); #1;
        check("rst_tx", bus.tx_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rre", bus.ram_read_enable, 0);
        check("rst_addr", bus.ram_address, 0);
        check("rst_bytes_sent", bus.bytes_sent, 0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check_idle("idle_after_release", 10);

        mem[12'h010] = 8'hA5;
        mem[12'h011] = 8'h3C;
        mem[12'h012] = 8'h0F;
        run_pkt(12'h010, 12'd3, -1, 1'b0);
        run_pkt(12'($urandom), 12'd0, -1, 1'b0);
        run_pkt(12'hFFE, 12'd4, -1, 1'b0);
        run_pkt(12'($urandom), 12'd5, -1, 1'b1);
        run_pkt(12'($urandom), 12'd6, 1000, 1'b0);
        mem[12'h020] = 8'h5A;
        run_pkt(12'h020, 12'd3, 680, 1'b0);
        run_pkt(12'h020, 12'd1, -1, 1'b0);
        for (int r = 0; r < 3; r++)
            run_pkt(12'($urandom), 12'($urandom_range(0, 5)), -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
